spi_apb_bridge: RTL

Converts the 32-bit words assembled by the 8-bit SPI slave front end into APB3 transactions and returns read data to it. It sits directly downstream of the SPI slave: it takes an assembled address/data word plus a direction flag and drives one APB access per request. Read results go back to the front end's read-data input. A one-deep holding register absorbs a request that arrives while an access is still in flight.

---
 rtl/spi_apb_bridge.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/spi_apb_bridge.sv
// spi_apb_bridge
// Turns address/data requests from the SPI slave front end into APB3 accesses.
// It issues one APB access per request and returns read data to the front end.
// A one-deep holding register keeps a request that arrives while an access is
// still running.
//
// Optional feature macro: ACCESS_TIMEOUT_EN. When it is defined, an ACCESS
// phase that waits too long is aborted after TIMEOUT_CYCLES cycles.
//
// Ports:
//   clk, rst_n           clock and asynchronous active-low reset
//   req_i, wr_i          request strobe and direction (1 = read)
//   addr_i, wdata_i      request address and write data
//   busy_o               access in flight or holding register full
//   rdata_o, rvalid_o    read data and its one-cycle valid pulse
//   err_o, ovf_o         slave-error/timeout pulse and dropped-request pulse
//   psel_o, penable_o, pwrite_o, paddr_o, pwdata_o   APB master outputs
//   prdata_i, pready_i, pslverr_i                    APB slave responses
module spi_apb_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] RD_ERR_DATA    = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_i,
    input  logic        wr_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        busy_o,
    output logic [31:0] rdata_o,
    output logic        rvalid_o,
    output logic        err_o,
    output logic        ovf_o,
    output logic        psel_o,
    output logic        penable_o,
    output logic        pwrite_o,
    output logic [31:0] paddr_o,
    output logic [31:0] pwdata_o,
    input  logic [31:0] prdata_i,
    input  logic        pready_i,
    input  logic        pslverr_i
);

    typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS} state_t;

    state_t      state_q, state_d;
    logic [31:0] paddr_q, paddr_d;
    logic [31:0] pwdata_q, pwdata_d;
    logic        pwrite_q, pwrite_d;
    logic        hold_valid_q, hold_valid_d;
    logic [31:0] hold_addr_q, hold_addr_d;
    logic [31:0] hold_wdata_q, hold_wdata_d;
    logic        hold_wr_q, hold_wr_d;
    logic [31:0] rdata_q, rdata_d;
    logic        rvalid_q, rvalid_d;
    logic        err_q, err_d;
    logic        ovf_q, ovf_d;
    logic        busy_q, busy_d;
    logic        timeout_w;
    logic        done_w;

`ifdef ACCESS_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] tcnt_q, tcnt_d;

    // The count equals the number of ACCESS cycles already spent waiting, so
    // the abort fires in the TIMEOUT_CYCLES-th ACCESS cycle.
    assign timeout_w = (state_q == ST_ACCESS) && !pready_i && (tcnt_q == TO_LAST);

    always_comb begin
        tcnt_d = tcnt_q;
        if (state_q == ST_SETUP) begin
            tcnt_d = 8'd0;
        end else if ((state_q == ST_ACCESS) && !pready_i) begin
            tcnt_d = tcnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt_q <= 8'd0;
        end else begin
            tcnt_q <= tcnt_d;
        end
    end
`else
    assign timeout_w = 1'b0;
`endif

    assign done_w = (state_q == ST_ACCESS) && (pready_i || timeout_w);

    always_comb begin
        state_d      = state_q;
        paddr_d      = paddr_q;
        pwdata_d     = pwdata_q;
        pwrite_d     = pwrite_q;
        hold_valid_d = hold_valid_q;
        hold_addr_d  = hold_addr_q;
        hold_wdata_d = hold_wdata_q;
        hold_wr_d    = hold_wr_q;
        rdata_d      = rdata_q;
        rvalid_d     = 1'b0;
        err_d        = 1'b0;
        ovf_d        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_i) begin
                    state_d  = ST_SETUP;
                    paddr_d  = addr_i & ~32'h3;
                    pwdata_d = wdata_i;
                    pwrite_d = ~wr_i;
                end
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
                if (req_i) begin
                    if (hold_valid_q) begin
                        ovf_d = 1'b1;
                    end else begin
                        hold_valid_d = 1'b1;
                        hold_addr_d  = addr_i;
                        hold_wdata_d = wdata_i;
                        hold_wr_d    = wr_i;
                    end
                end
            end
            ST_ACCESS: begin
                if (done_w) begin
                    if (!pwrite_q) begin
                        rdata_d  = timeout_w ? RD_ERR_DATA : prdata_i;
                        rvalid_d = 1'b1;
                    end
                    err_d = timeout_w || pslverr_i;
                    if (hold_valid_q) begin
                        // Held request goes out next; a same-cycle request
                        // takes the slot it just vacated.
                        state_d      = ST_SETUP;
                        paddr_d      = hold_addr_q & ~32'h3;
                        pwdata_d     = hold_wdata_q;
                        pwrite_d     = ~hold_wr_q;
                        hold_valid_d = req_i;
                        if (req_i) begin
                            hold_addr_d  = addr_i;
                            hold_wdata_d = wdata_i;
                            hold_wr_d    = wr_i;
                        end
                    end else if (req_i) begin
                        state_d  = ST_SETUP;
                        paddr_d  = addr_i & ~32'h3;
                        pwdata_d = wdata_i;
                        pwrite_d = ~wr_i;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (req_i) begin
                    if (hold_valid_q) begin
                        ovf_d = 1'b1;
                    end else begin
                        hold_valid_d = 1'b1;
                        hold_addr_d  = addr_i;
                        hold_wdata_d = wdata_i;
                        hold_wr_d    = wr_i;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE) || hold_valid_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            paddr_q      <= 32'h0;
            pwdata_q     <= 32'h0;
            pwrite_q     <= 1'b0;
            hold_valid_q <= 1'b0;
            hold_addr_q  <= 32'h0;
            hold_wdata_q <= 32'h0;
            hold_wr_q    <= 1'b0;
            rdata_q      <= 32'h0;
            rvalid_q     <= 1'b0;
            err_q        <= 1'b0;
            ovf_q        <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            paddr_q      <= paddr_d;
            pwdata_q     <= pwdata_d;
            pwrite_q     <= pwrite_d;
            hold_valid_q <= hold_valid_d;
            hold_addr_q  <= hold_addr_d;
            hold_wdata_q <= hold_wdata_d;
            hold_wr_q    <= hold_wr_d;
            rdata_q      <= rdata_d;
            rvalid_q     <= rvalid_d;
            err_q        <= err_d;
            ovf_q        <= ovf_d;
            busy_q       <= busy_d;
        end
    end

    assign psel_o    = (state_q != ST_IDLE);
    assign penable_o = (state_q == ST_ACCESS);
    assign pwrite_o  = pwrite_q;
    assign paddr_o   = paddr_q;
    assign pwdata_o  = pwdata_q;
    assign rdata_o   = rdata_q;
    assign rvalid_o  = rvalid_q;
    assign err_o     = err_q;
    assign ovf_o     = ovf_q;
    assign busy_o    = busy_q;

endmodule
